// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  // Widest register the read-response struct can carry; narrower files zero-extend.
  localparam int MAX_DATA_W = 64;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic                  ready;
  } rd_resp_t;

  // A read port takes the in-flight writeback value when it targets the write address;
  // the hardwired zero register is never forwarded.
  function automatic logic bypass_sel(input logic wr_en, input logic addr_match,
                                      input logic addr_zero, input logic zero_reg);
    return wr_en && addr_match && !(zero_reg && addr_zero);
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the regfile_sb register file.
interface regfile_sb_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  // wr_en and rsv_en are single-cycle strobes sampled on the falling edge with no
  // backpressure; rdN_ready means the addressed operand has no pending writeback.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] rd1_addr;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_ready;
  logic [ADDR_W-1:0] rd2_addr;
  logic [DATA_W-1:0] rd2_data;
  logic              rd2_ready;
  logic [ADDR_W:0]   busy_cnt;

  modport slave (
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd1_addr, rd2_addr,
    output rd1_data, rd1_ready, rd2_data, rd2_ready, busy_cnt
  );

  modport master (
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd1_addr, rd2_addr,
    input  rd1_data, rd1_ready, rd2_data, rd2_ready, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered busy count.
module regfile_scoreboard #(
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  output logic [2**ADDR_W-1:0] busy_vec,
  output logic [ADDR_W:0]      busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             wr_eff, rsv_eff, inc, dec;

  always_comb begin
    wr_eff  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
    rsv_eff = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
    busy_d  = busy_q;
    if (wr_eff)  busy_d[wr_addr]  = 1'b0;
    // Reserve applied last so a same-address write+reserve leaves the register busy.
    if (rsv_eff) busy_d[rsv_addr] = 1'b1;
    inc   = rsv_eff && !busy_q[rsv_addr];
    dec   = wr_eff && busy_q[wr_addr] && !(rsv_eff && rsv_addr == wr_addr);
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + 1'b1;
    else if (dec && !inc) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Two-read-port register file with pending-write scoreboard, updated on the falling edge.
// Define REGFILE_BYPASS_EN to forward the in-flight writeback value to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic              wr_eff;
  logic [ADDR_W-1:0] rd_addr [2];
  rd_resp_t          resp [2];

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .busy_vec (busy_vec),
    .busy_cnt (bus.busy_cnt)
  );

  always_comb begin
    wr_eff = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
    data_d = data_q;
    if (wr_eff) data_d[bus.wr_addr] = bus.wr_data;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) data_q <= '{default: '0};
    else       data_q <= data_d;
  end

  assign rd_addr[0] = bus.rd1_addr;
  assign rd_addr[1] = bus.rd2_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      resp[p].data  = MAX_DATA_W'(data_q[rd_addr[p]]);
      resp[p].ready = ~busy_vec[rd_addr[p]];
      if (ZERO_REG != 0 && rd_addr[p] == '0) begin
        resp[p].data  = '0;
        resp[p].ready = 1'b1;
      end
`ifdef REGFILE_BYPASS_EN
      if (bypass_sel(bus.wr_en, rd_addr[p] == bus.wr_addr, rd_addr[p] == '0, ZERO_REG != 0)) begin
        resp[p].data  = MAX_DATA_W'(bus.wr_data);
        resp[p].ready = !(bus.rsv_en && bus.rsv_addr == bus.wr_addr);
      end
`endif
    end
  end

  assign bus.rd1_data  = resp[0].data[DATA_W-1:0];
  assign bus.rd1_ready = resp[0].ready;
  assign bus.rd2_data  = resp[1].data[DATA_W-1:0];
  assign bus.rd2_ready = resp[1].ready;

  // Upper response bits beyond DATA_W are always zero and intentionally dropped.
  logic unused_resp;
  assign unused_resp = &{1'b0, resp[0].data, resp[1].data};
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register pending-write scoreboard for the lab CPU datapath. It generalises the fixed 8×8, two-read-port register file:
- data width and depth are configurable;
- writes are enable-gated, with an optional hardwired zero register;
- the file tracks which registers await a result from a multi-cycle unit, so decode can stall on a not-ready operand.

It sits between instruction decode (reserve and read) and writeback (write).

## Interface
Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W
- ZERO_REG, 0, 1 = register 0 always reads 0; writes and reserves to it are ignored

Ports:
- clk  in  1  clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback value
- rsv_en  in  1  reserve request from decode
- rsv_addr  in  ADDR_W  register to mark busy
- rd1_addr  in  ADDR_W  read port 1 address
- rd1_data  out  DATA_W  read port 1 value
- rd1_ready  out  1  read port 1 operand not busy
- rd2_addr  in  ADDR_W  read port 2 address
- rd2_data  out  DATA_W  read port 2 value
- rd2_ready  out  1  read port 2 operand not busy
- busy_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- State: DEPTH data registers, each with one busy bit.
- Write on a falling edge with wr_en=1: data[wr_addr] <= wr_data; busy[wr_addr] <= 0.
- Reserve on a falling edge with rsv_en=1: busy[rsv_addr] <= 1. Reserving an already-busy register keeps it busy; reservations do not stack.
- Write and reserve to the same address on one edge: data is updated and busy ends at 1, because the new reservation wins.
- Write and reserve to different addresses on one edge: both take effect.
- A write to a non-busy register is legal and updates the data.
- Reads are combinational: rdN_data = data[rdN_addr] and rdN_ready = ~busy[rdN_addr].
- ZERO_REG=1:
  - address 0 always reads data 0 with ready 1;
  - writes and reserves to address 0 have no effect;
  - address 0 is never counted in busy_cnt.
- busy_cnt is a registered population count of the busy bits.
  - It changes by +1, −1 or 0 per edge, and is updated on the same edge as the busy bits.
  - Range is 0..DEPTH; the counter never wraps.

## Timing
- Reset values: all data = 0, all busy = 0, busy_cnt = 0. Consequently rdN_data = 0 and rdN_ready = 1.
- Reset asserted mid-operation clears state asynchronously. Any write or reserve on an edge while reset is high is discarded.
- Write latency:
  - new data is visible on the read ports after the falling edge;
  - there is no same-cycle visibility unless bypass is compiled in (see Configuration).
- Reserve latency: rdN_ready falls after the falling edge on which rsv_en was sampled.
- A rising edge of clk has no effect on any state.

## Configuration
- REGFILE_BYPASS_EN defined: when wr_en=1 and rdN_addr == wr_addr, the port returns rdN_data = wr_data and rdN_ready = 1 combinationally, before the edge.
  - Exception: if rsv_en=1 with rsv_addr == wr_addr in the same cycle, rdN_ready = 0.
  - Under ZERO_REG=1, address 0 is never bypassed.
- REGFILE_BYPASS_EN undefined: read ports reflect stored state only.

## Structure
- Shared package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - a read-port response typedef (data + ready);
  - the bypass-select helper function.
- One sub-module, regfile_scoreboard, holds the busy bits and busy_cnt. It takes wr/rsv enables and addresses plus ZERO_REG, and provides the per-address busy vector.
- The data array and read muxes stay in the top module.

## Test plan
- Reset then idle: rd1_addr=5 → rd1_data=0, rd1_ready=1, busy_cnt=0.
- Write 8'h2A to r3 on one negedge, read r3 on both ports → 8'h2A, ready=1. Without bypass, the value is not visible before the edge.
- Reserve r4 → rd1_ready=0 and busy_cnt=1. A later write of 8'h11 to r4 → ready=1, data 8'h11, busy_cnt=0.
- Same edge: write 8'h77 to r2 and reserve r2 → data 8'h77, ready=0, busy_cnt=1. Same edge: write r2 and reserve r6 → r2 ready, r6 busy, busy_cnt=1.
- ZERO_REG=1: write 8'hFF to r0 and reserve r0 → r0 reads 0, ready=1, busy_cnt unchanged.
- Reserve r1 and r7 (busy_cnt=2), then assert reset between edges → busy_cnt=0 and all ready immediately. An edge with wr_en while reset=1 leaves data 0.
- REGFILE_BYPASS_EN: wr_en=1, wr_addr=5, wr_data=8'h3C, rd2_addr=5 → rd2_data=8'h3C and rd2_ready=1 before the edge.
